// File: rtl/serial_ctrl.sv
// Shift-sequence controller: loads operand registers, runs NBITS shift cycles per
// Execute high period, then holds Done until Execute falls.
module serial_ctrl #(
  parameter int NBITS = 8,
  parameter int CW    = $clog2(NBITS + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          LoadA,
  input  logic          LoadB,
  input  logic          Execute,
  input  logic          Abort,
  input  logic          Dir_In,
  output logic          Shift_En,
  output logic          Ld_A,
  output logic          Ld_B,
  output logic          Dir,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] Count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] count_nx;
  logic          dir_nx;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      Count <= '0;
      Dir   <= 1'b0;
    end else begin
      state <= state_nx;
      Count <= count_nx;
      Dir   <= dir_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = Count;
    dir_nx   = Dir;
    case (state)
      IDLE: begin
        count_nx = '0;
        if (Execute) begin
          state_nx = SHIFT;
          count_nx = CW'(NBITS);
          dir_nx   = Dir_In;
        end
      end
      SHIFT: begin
        if (Abort) begin
          state_nx = IDLE;
          count_nx = '0;
        end else if (Count <= CW'(1)) begin
          // Last shift cycle; the <= also keeps a corrupted zero from wrapping
          state_nx = HOLD;
          count_nx = '0;
        end else begin
          count_nx = Count - CW'(1);
        end
      end
      HOLD: begin
        count_nx = '0;
        if (!Execute || Abort) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        count_nx = '0;
      end
    endcase
  end

  assign Busy     = (state == SHIFT);
  assign Done     = (state == HOLD);
  assign Shift_En = (state == SHIFT) && !Abort;
  assign Ld_A     = (state == IDLE) && LoadA;
  assign Ld_B     = (state == IDLE) && LoadB;

endmodule

// File: tb/tb_serial_ctrl.sv
// Directed bench for serial_ctrl: per-cycle expected observations queued by the
// stimulus and checked by an independent negedge monitor, for NBITS=8 and NBITS=1.
module tb_serial_ctrl;

  typedef struct packed {
    logic exec;
    logic abort;
    logic la;
    logic lb;
    logic din;
  } stim_t;

  typedef struct packed {
    logic       se;
    logic       busy;
    logic       done;
    logic       lda;
    logic       ldb;
    logic       dir;
    logic [3:0] cnt;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic exec8, abort8, la8, lb8, din8;
  logic se8, lda8, ldb8, dir8, busy8, done8;
  logic [3:0] cnt8;
  logic exec1, abort1, la1, lb1, din1;
  logic se1, lda1, ldb1, dir1, busy1, done1;
  logic [0:0] cnt1;

  serial_ctrl #(.NBITS(8)) dut8 (
    .Clk(clk), .Reset(rst_n), .LoadA(la8), .LoadB(lb8), .Execute(exec8),
    .Abort(abort8), .Dir_In(din8), .Shift_En(se8), .Ld_A(lda8), .Ld_B(ldb8),
    .Dir(dir8), .Busy(busy8), .Done(done8), .Count(cnt8)
  );

  serial_ctrl #(.NBITS(1)) dut1 (
    .Clk(clk), .Reset(rst_n), .LoadA(la1), .LoadB(lb1), .Execute(exec1),
    .Abort(abort1), .Dir_In(din1), .Shift_En(se1), .Ld_A(lda1), .Ld_B(ldb1),
    .Dir(dir1), .Busy(busy1), .Done(done1), .Count(cnt1)
  );

  obs_t q8[$];
  obs_t q1[$];
  obs_t e8, a8, e1, a1;
  int   checks = 0;
  int   failures = 0;
  int   cyc_n = 0;

  function automatic stim_t st(input logic ex, input logic ab, input logic la,
                               input logic lb, input logic din);
    stim_t s;
    s.exec = ex; s.abort = ab; s.la = la; s.lb = lb; s.din = din;
    return s;
  endfunction

  function automatic obs_t mk(input logic se, input logic busy, input logic done,
                              input logic lda, input logic ldb, input logic dir,
                              input int cnt);
    obs_t o;
    o.se = se; o.busy = busy; o.done = done; o.lda = lda; o.ldb = ldb;
    o.dir = dir; o.cnt = 4'(cnt);
    return o;
  endfunction

  function automatic obs_t idle(input logic dir);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, dir, 0);
  endfunction

  // Monitor: compare one queued observation per DUT per cycle, mid-cycle
  always @(negedge clk) begin
    if (q8.size() > 0) begin
      e8 = q8.pop_front();
      a8 = {se8, busy8, done8, lda8, ldb8, dir8, cnt8};
      checks++;
      if (a8 !== e8) begin
        failures++;
        $display("FAIL dut8 cyc=%0d got se/busy/done/lda/ldb/dir=%b%b%b%b%b%b cnt=%0d exp %b%b%b%b%b%b cnt=%0d",
                 cyc_n, a8.se, a8.busy, a8.done, a8.lda, a8.ldb, a8.dir, a8.cnt,
                 e8.se, e8.busy, e8.done, e8.lda, e8.ldb, e8.dir, e8.cnt);
      end
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      a1 = {se1, busy1, done1, lda1, ldb1, dir1, 3'b000, cnt1};
      checks++;
      if (a1 !== e1) begin
        failures++;
        $display("FAIL dut1 cyc=%0d got se/busy/done/lda/ldb/dir=%b%b%b%b%b%b cnt=%0d exp %b%b%b%b%b%b cnt=%0d",
                 cyc_n, a1.se, a1.busy, a1.done, a1.lda, a1.ldb, a1.dir, a1.cnt,
                 e1.se, e1.busy, e1.done, e1.lda, e1.ldb, e1.dir, e1.cnt);
      end
    end
  end

  task automatic cyc(input logic rst, input stim_t s8, input obs_t x8,
                     input stim_t s1, input obs_t x1);
    @(posedge clk);
    #1;
    cyc_n++;
    rst_n = rst;
    {exec8, abort8, la8, lb8, din8} = s8;
    {exec1, abort1, la1, lb1, din1} = s1;
    q8.push_back(x8);
    q1.push_back(x1);
  endtask

  task automatic c8(input logic rst, input stim_t s8, input obs_t x8);
    cyc(rst, s8, x8, st(0, 0, 0, 0, 0), idle(1'b0));
  endtask

  stim_t s0;

  initial begin
    s0 = st(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    {exec8, abort8, la8, lb8, din8} = '0;
    {exec1, abort1, la1, lb1, din1} = '0;

    // Reset state; load strobes still pass through while in reset
    c8(1'b0, st(0, 0, 1, 0, 0), mk(0, 0, 0, 1, 0, 0, 0));
    c8(1'b0, st(0, 0, 0, 1, 0), mk(0, 0, 0, 0, 1, 0, 0));
    c8(1'b1, s0, idle(1'b0));
    c8(1'b1, s0, idle(1'b0));

    // Single-cycle Execute together with LoadB; LoadA blocked mid-shift
    c8(1'b1, st(1, 0, 0, 1, 0), mk(0, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 8; i++)
      c8(1'b1, st(0, 0, (i == 2), 0, 0), mk(1, 1, 0, 0, 0, 0, 8 - i));
    c8(1'b1, s0, mk(0, 0, 1, 0, 0, 0, 0));
    c8(1'b1, s0, idle(1'b0));
    c8(1'b1, s0, idle(1'b0));

    // Execute held 20 cycles, Dir_In=1 at start then toggling; loads blocked in HOLD
    c8(1'b1, st(1, 0, 0, 0, 1), idle(1'b0));
    for (int i = 0; i < 8; i++)
      c8(1'b1, st(1, 0, 0, 0, i[0]), mk(1, 1, 0, 0, 0, 1, 8 - i));
    for (int i = 9; i < 20; i++)
      c8(1'b1, st(1, 0, 1, 1, 0), mk(0, 0, 1, 0, 0, 1, 0));
    c8(1'b1, s0, mk(0, 0, 1, 0, 0, 1, 0));
    c8(1'b1, s0, idle(1'b1));
    c8(1'b1, s0, idle(1'b1));

    // Abort on the 4th shift cycle
    c8(1'b1, st(1, 0, 0, 0, 0), idle(1'b1));
    for (int i = 0; i < 3; i++)
      c8(1'b1, s0, mk(1, 1, 0, 0, 0, 0, 8 - i));
    c8(1'b1, st(0, 1, 0, 0, 0), mk(0, 1, 0, 0, 0, 0, 5));
    c8(1'b1, s0, idle(1'b0));
    c8(1'b1, s0, idle(1'b0));

    // Asynchronous reset where Count would be 5, then wait idle after release
    c8(1'b1, st(1, 0, 0, 0, 1), idle(1'b0));
    for (int i = 0; i < 3; i++)
      c8(1'b1, s0, mk(1, 1, 0, 0, 0, 1, 8 - i));
    c8(1'b0, s0, idle(1'b0));
    c8(1'b0, s0, idle(1'b0));
    c8(1'b1, s0, idle(1'b0));
    c8(1'b1, s0, idle(1'b0));
    c8(1'b1, s0, idle(1'b0));

    // NBITS=1 instance: one shift cycle, Count 1 then 0, HOLD next cycle
    cyc(1'b1, s0, idle(1'b0), st(1, 0, 0, 0, 1), idle(1'b0));
    cyc(1'b1, s0, idle(1'b0), s0, mk(1, 1, 0, 0, 0, 1, 1));
    cyc(1'b1, s0, idle(1'b0), s0, mk(0, 0, 1, 0, 0, 1, 0));
    cyc(1'b1, s0, idle(1'b0), s0, idle(1'b1));
    cyc(1'b1, s0, idle(1'b0), s0, idle(1'b1));

    for (int k = 0; k < 5 && (q8.size() > 0 || q1.size() > 0); k++)
      @(posedge clk);
    if (q8.size() > 0 || q1.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", q8.size() + q1.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_ctrl.md
SERIAL_CTRL -- requirements
Module: serial_ctrl

Interface
REQ-001 Parameter NBITS, default 8, number of shift cycles per operation; legal range 1..255.
REQ-002 Parameter CW, default $clog2(NBITS+1), width of Count; not overridden by instantiators.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low; asserting it (0) forces reset state immediately, independent of Clk.
REQ-005 LoadA  input  1  request to parallel-load register A.
REQ-006 LoadB  input  1  request to parallel-load register B.
REQ-007 Execute  input  1  level-sensitive start; operation runs once per high period.
REQ-008 Abort  input  1  synchronous cancel of an operation in progress.
REQ-009 Dir_In  input  1  shift direction request (0 = right, 1 = left), sampled at start.
REQ-010 Shift_En  output  1  shift-enable to the register chain.
REQ-011 Ld_A  output  1  load strobe for register A.
REQ-012 Ld_B  output  1  load strobe for register B.
REQ-013 Dir  output  1  latched direction for the current operation.
REQ-014 Busy  output  1  high while shifting.
REQ-015 Done  output  1  high while holding after a completed operation.
REQ-016 Count  output  CW  shift cycles remaining.

Function
REQ-017 Three states SHALL exist: IDLE, SHIFT, HOLD.
REQ-018 IDLE: Execute=1 at an edge -> SHIFT; Count <= NBITS; Dir <= Dir_In. Otherwise IDLE is retained.
REQ-019 SHIFT: Count SHALL decrement by 1 per cycle. When Count==1, the next edge SHALL go to HOLD with Count <= 0.
REQ-020 Shift_En SHALL be high for exactly NBITS consecutive cycles: Execute sampled at edge k -> Shift_En high in cycles k+1..k+NBITS.
REQ-021 Shift_En = (state==SHIFT) AND NOT Abort; Busy = (state==SHIFT).
REQ-022 Abort=1 in SHIFT -> IDLE at the next edge; Count <= 0; Done SHALL NOT assert; HOLD SHALL NOT be entered.
REQ-023 HOLD: Done=1; Execute=0 or Abort=1 at an edge -> IDLE. While Execute stays high, HOLD is retained and no further shifting occurs.
REQ-024 Ld_A = LoadA and Ld_B = LoadB in IDLE only; both SHALL be 0 in SHIFT and HOLD regardless of inputs.
REQ-025 Execute and LoadA/LoadB high together in IDLE: the load strobes pass for that cycle, and SHIFT starts next cycle.
REQ-026 Dir SHALL hold its latched value through SHIFT and HOLD; Dir_In changes mid-operation are ignored.
REQ-027 Count SHALL never underflow; it holds 0 in IDLE and HOLD.
REQ-028 Execute dropping during SHIFT SHALL NOT stop shifting; the operation completes to HOLD, then returns to IDLE on the next edge.
REQ-029 All outputs are functions of state and registers only, except Ld_A, Ld_B and Shift_En, which also gate on the listed inputs.

Reset
REQ-030 Reset=0 SHALL asynchronously force state IDLE, Count=0, Dir=0; this yields Shift_En=0, Busy=0, Done=0, Ld_A=LoadA, Ld_B=LoadB.
REQ-031 Reset asserted mid-SHIFT SHALL abandon the operation with no further Shift_En pulses. After Reset=1, the block waits in IDLE for Execute.
REQ-032 First state change after reset release SHALL occur no earlier than the first rising Clk edge following the release.

Verification
REQ-033 NBITS=8, Execute high 1 cycle then low -> Shift_En high 8 cycles; Count 8,7..1; Done 1 cycle; back to IDLE.
REQ-034 NBITS=8, Execute held high 20 cycles -> exactly 8 Shift_En cycles; Done high cycles 9..20; IDLE one edge after Execute falls.
REQ-035 Abort pulsed at 4th SHIFT cycle -> Shift_En 0 in that cycle; total 3 shift pulses; Done never 1; IDLE next edge.
REQ-036 Reset low asynchronously at mid-SHIFT (Count=5) -> Busy/Shift_En 0 before next edge; Count=0.
REQ-037 LoadA=1 in IDLE -> Ld_A=1. LoadA=1 in SHIFT -> Ld_A=0. Dir_In=1 at start, toggled mid-shift -> Dir stays 1.
REQ-038 NBITS=1, single Execute -> one Shift_En cycle; Count 1 then 0; HOLD next cycle.
